hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage LoongArch integer core. It tracks destination-register records for the instructions in EX and MEM. From those records it drives the forwardEX/forwardMEM selects of the rs1 and rs2 operand muxes. It also generates load-use and multi-cycle-divide stalls, and handles branch flush of the ID slot. It sits beside the ID/EX pipeline register and is the only source of operand-select and stall signals.

Parameters:
DIV_LAT, 4, total cycles a divide occupies EX (≥2)
REG_AW, 5, register index width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_AW  source reg 1 index
id_rs2  in  REG_AW  source reg 2 index
id_rs1_used  in  1  instruction reads rs1 (else PC selected)
id_rs2_used  in  1  instruction reads rs2 (else imm selected)
id_rd  in  REG_AW  destination index
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_is_div  in  1  instruction is div/mod
flush  in  1  branch taken in EX; kill ID instruction
fwd_ex_rs1  out  1  rs1 select EX_alu_result
fwd_mem_rs1  out  1  rs1 select MEM_dm_data
fwd_ex_rs2  out  1  rs2 select EX_alu_result
fwd_mem_rs2  out  1  rs2 select MEM_dm_data
stall_id  out  1  hold PC and IF/ID
stall_ex  out  1  hold ID/EX (divide busy)
issue  out  1  ID instruction accepted into EX this cycle
ex_bubble  out  1  EX receives a bubble next edge

Behaviour:
- Internal state:
  - EX record {v, rd, we, ld, div}
  - MEM record {v, rd, we}
  - div_cnt (clog2(DIV_LAT) bits)
- Reset: all records v=0, div_cnt=0. All outputs are 0 in the cycle rst is sampled high and stay 0 while rst is held. Reset mid-divide abandons the divide.
- A record "hits" a source when v && we && rd==src && src!=0. r0 is never forwarded or stalled on.
- Forwarding (combinational from records, per source, gated by *_used):
  - fwd_ex = EX hits && !EX.ld
  - fwd_mem = MEM hits && !fwd_ex. EX has priority over MEM.
- Load-use: lu = id_valid && EX.ld && (EX hits rs1&&rs1_used || EX hits rs2&&rs2_used).
- Divide busy: div_busy = div_cnt!=0.
- stall_ex = div_busy.
- stall_id = div_busy || lu.
- issue = id_valid && !stall_id && !flush.
- ex_bubble = !div_busy && !issue.
- Sequential update on each clk edge:
  - MEM ← div_busy ? invalid : EX record.
  - EX ← div_busy ? unchanged : (issue ? ID fields : invalid).
- div_cnt:
  - Loaded DIV_LAT-1 when issue && id_is_div.
  - Decrements while nonzero.
  - Otherwise 0.
  - The divide therefore holds EX for DIV_LAT-1 extra cycles. Its result is forwarded from EX (fwd_ex) only in its final EX cycle; earlier, dependents are already stalled by stall_id.
- flush: ID instruction is dropped (issue=0, EX gets bubble). flush has priority over lu. If flush coincides with div_busy, the ID instruction is still dropped and stall_ex is unchanged.
- Latency:
  - Forward selects are valid in the same cycle as ID inputs.
  - Load-use costs exactly 1 bubble.
  - Divide costs DIV_LAT-1 stall cycles.
- Back-to-back divides: the second stalls in ID until div_cnt reaches 0, then issues and reloads the counter.

Test Plan:
- Forwarding, ALU chain: issue add r5; next cycle ID reads rs1=r5 → fwd_ex_rs1=1, fwd_mem_rs1=0. One cycle later (ID rs2=r5, used) → fwd_mem_rs2=1.
- Double hit: EX and MEM both write r7, ID rs1=r7 → fwd_ex_rs1=1, fwd_mem_rs1=0. With rd=r0 and ID rs1=r0 → all forwards 0.
- Load-use: ld r3 in EX, ID rs2=r3 used:
  - stall_id=1, issue=0, ex_bubble=1 for 1 cycle.
  - Next cycle fwd_mem_rs2=1, issue=1.
  - With rs2_used=0 → no stall.
- Divide, DIV_LAT=4: div r9 issues; dependent rs1=r9 in ID:
  - stall_ex=stall_id=1 for 3 cycles; MEM sees 3 bubbles.
  - Then fwd_ex_rs1=1 and issue=1.
- Flush: flush=1 while lu=1 → issue=0, stall_id=1, EX bubble, ID instruction never reaches MEM. Flush during div_busy → div completes unaffected.
- Reset mid-divide at cycle 2 → all outputs 0, div_cnt=0, next instruction issues immediately after rst drops.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX/MEM dest-record tracking, operand forwarding, load-use/divide stalls and ID flush.
module hazard_forward_ctrl #(
  parameter int DIV_LAT = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_div,
  input  logic              flush,
  output logic              fwd_ex_rs1,
  output logic              fwd_mem_rs1,
  output logic              fwd_ex_rs2,
  output logic              fwd_mem_rs2,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              issue,
  output logic              ex_bubble
);
  localparam int CW = $clog2(DIV_LAT);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
    logic              div;
  } ex_rec_t;
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
  } mem_rec_t;
  ex_rec_t ex_q, ex_d;
  mem_rec_t mem_q, mem_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic div_busy, ex_h1, ex_h2, mem_h1, mem_h2, f_ex1, f_ex2, lu, stall, iss;
  function automatic logic hit(input logic v, input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] src);
    return v && we && rd == src && src != '0;
  endfunction
  always_comb begin
    div_busy = div_cnt_q != '0 && ex_q.div;
    ex_h1 = id_rs1_used && hit(ex_q.v, ex_q.we, ex_q.rd, id_rs1);
    ex_h2 = id_rs2_used && hit(ex_q.v, ex_q.we, ex_q.rd, id_rs2);
    mem_h1 = id_rs1_used && hit(mem_q.v, mem_q.we, mem_q.rd, id_rs1);
    mem_h2 = id_rs2_used && hit(mem_q.v, mem_q.we, mem_q.rd, id_rs2);
    f_ex1 = ex_h1 && !ex_q.ld;
    f_ex2 = ex_h2 && !ex_q.ld;
    lu = id_valid && ex_q.ld && (ex_h1 || ex_h2);
    stall = div_busy || lu;
    iss = id_valid && !stall && !flush;
    // a busy divide freezes EX and feeds MEM bubbles until its last cycle
    mem_d = div_busy ? mem_rec_t'('0) : mem_rec_t'{ex_q.v, ex_q.rd, ex_q.we};
    ex_d = div_busy ? ex_q : iss ? ex_rec_t'{1'b1, id_rd, id_we, id_is_load, id_is_div} : ex_rec_t'('0);
    div_cnt_d = iss && id_is_div ? CW'(DIV_LAT - 1) : div_busy ? div_cnt_q - CW'(1) : '0;
    fwd_ex_rs1 = !rst && f_ex1;
    fwd_ex_rs2 = !rst && f_ex2;
    fwd_mem_rs1 = !rst && mem_h1 && !f_ex1;
    fwd_mem_rs2 = !rst && mem_h2 && !f_ex2;
    stall_id = !rst && stall;
    stall_ex = !rst && div_busy;
    issue = !rst && iss;
    ex_bubble = !rst && !div_busy && !iss;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      div_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      div_cnt_q <= div_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed scenarios plus randomized run against a pipeline-occupancy model.
module tb_hazard_forward_ctrl;
  localparam int DIV_LAT = 4;
  localparam int REG_AW = 5;
  logic clk = 0, rst = 1;
  logic id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, id_is_div, flush;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic fwd_ex_rs1, fwd_mem_rs1, fwd_ex_rs2, fwd_mem_rs2, stall_id, stall_ex, issue, ex_bubble;
  logic [7:0] outs;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  hazard_forward_ctrl #(.DIV_LAT(DIV_LAT), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_div(id_is_div), .flush(flush),
    .fwd_ex_rs1(fwd_ex_rs1), .fwd_mem_rs1(fwd_mem_rs1), .fwd_ex_rs2(fwd_ex_rs2),
    .fwd_mem_rs2(fwd_mem_rs2), .stall_id(stall_id), .stall_ex(stall_ex), .issue(issue),
    .ex_bubble(ex_bubble));
  // bit order: fe1 fm1 fe2 fm2 stall_id stall_ex issue ex_bubble
  assign outs = {fwd_ex_rs1, fwd_mem_rs1, fwd_ex_rs2, fwd_mem_rs2, stall_id, stall_ex, issue, ex_bubble};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int r1, input int r2, input logic u1, input logic u2,
                        input int rd, input logic we, input logic ld, input logic dv, input logic fl);
    id_valid = v; id_rs1 = REG_AW'(r1); id_rs2 = REG_AW'(r2); id_rs1_used = u1; id_rs2_used = u2;
    id_rd = REG_AW'(rd); id_we = we; id_is_load = ld; id_is_div = dv; flush = fl;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1;
    set_id(1, 3, 4, 1, 1, 5, 1, 0, 1, 0);
    step();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (outs !== 8'b0) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, 8'b0); end
      step();
    end
    rst = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00000001) begin errors++; $display("FAIL reset_idle got=%b exp=%b", outs, 8'b00000001); end
    step();
  endtask

  task automatic test_alu_chain();
    idle(2);
    set_id(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00000010) begin errors++; $display("FAIL alu_issue got=%b exp=%b", outs, 8'b00000010); end
    step();
    set_id(1, 5, 0, 1, 1, 6, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b10000010) begin errors++; $display("FAIL alu_fwd_ex got=%b exp=%b", outs, 8'b10000010); end
    step();
    set_id(1, 1, 5, 1, 1, 7, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00010010) begin errors++; $display("FAIL alu_fwd_mem got=%b exp=%b", outs, 8'b00010010); end
    step();
    idle(2);
  endtask

  task automatic test_double_hit();
    set_id(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
    step();
    step();
    set_id(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b10100010) begin errors++; $display("FAIL dbl_hit got=%b exp=%b", outs, 8'b10100010); end
    step();
    idle(2);
    set_id(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
    step();
    step();
    set_id(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00000010) begin errors++; $display("FAIL r0_no_fwd got=%b exp=%b", outs, 8'b00000010); end
    step();
    idle(2);
  endtask

  task automatic test_load_use();
    set_id(1, 1, 2, 1, 1, 3, 1, 1, 0, 0);
    step();
    set_id(1, 1, 3, 1, 1, 4, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00001001) begin errors++; $display("FAIL lu_stall got=%b exp=%b", outs, 8'b00001001); end
    step();
    @(negedge clk);
    checks++;
    if (outs !== 8'b00010010) begin errors++; $display("FAIL lu_release got=%b exp=%b", outs, 8'b00010010); end
    step();
    idle(2);
    set_id(1, 1, 2, 1, 1, 3, 1, 1, 0, 0);
    step();
    set_id(1, 4, 3, 1, 0, 4, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00000010) begin errors++; $display("FAIL lu_unused got=%b exp=%b", outs, 8'b00000010); end
    step();
    idle(2);
  endtask

  task automatic test_divide();
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 1, 0);
    step();
    set_id(1, 9, 0, 1, 0, 10, 1, 0, 0, 0);
    for (int i = 0; i < DIV_LAT - 1; i++) begin
      @(negedge clk);
      checks++;
      if (outs[3:0] !== 4'b1100) begin errors++; $display("FAIL div_stall%0d got=%b exp=1100", i, outs[3:0]); end
      step();
    end
    @(negedge clk);
    checks++;
    if (outs !== 8'b10000010) begin errors++; $display("FAIL div_done got=%b exp=%b", outs, 8'b10000010); end
    step();
    set_id(1, 0, 9, 0, 1, 11, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00010010) begin errors++; $display("FAIL div_mem got=%b exp=%b", outs, 8'b00010010); end
    step();
    idle(2);
  endtask

  task automatic test_flush();
    set_id(1, 1, 2, 1, 1, 3, 1, 1, 0, 0);
    step();
    set_id(1, 1, 3, 1, 1, 8, 1, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (outs !== 8'b00001001) begin errors++; $display("FAIL flush_lu got=%b exp=%b", outs, 8'b00001001); end
    step();
    repeat (2) begin
      set_id(0, 8, 8, 1, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (outs !== 8'b00000001) begin errors++; $display("FAIL flush_dropped got=%b exp=%b", outs, 8'b00000001); end
      step();
    end
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 1, 0);
    step();
    set_id(1, 0, 0, 0, 0, 11, 1, 0, 0, 1);
    for (int i = 0; i < DIV_LAT - 1; i++) begin
      @(negedge clk);
      checks++;
      if (outs[3:0] !== 4'b1100) begin errors++; $display("FAIL flush_div%0d got=%b exp=1100", i, outs[3:0]); end
      step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    set_id(1, 9, 0, 1, 0, 12, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b10000010) begin errors++; $display("FAIL flush_div_done got=%b exp=%b", outs, 8'b10000010); end
    step();
    idle(2);
  endtask

  task automatic test_reset_mid_div();
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 1, 0);
    step();
    set_id(1, 9, 0, 1, 0, 10, 1, 0, 0, 0);
    step();
    rst = 1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0) begin errors++; $display("FAIL rst_mid_div got=%b exp=%b", outs, 8'b0); end
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b00000010) begin errors++; $display("FAIL rst_resume got=%b exp=%b", outs, 8'b00000010); end
    step();
    idle(2);
  endtask

  // model: which instruction sits in EX/MEM and how many more cycles a divide holds EX
  task automatic test_random();
    bit ex_v = 0, ex_we = 0, ex_ld = 0, mem_v = 0, mem_we = 0;
    int ex_rd = 0, mem_rd = 0, hold = 0;
    bit e1, e2, m1, m2, fe1, fe2, lu, busy, sid, iss;
    logic [7:0] exp;
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 29) == 0;
      set_id($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
             $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0);
      busy = hold > 0;
      e1 = id_rs1_used && ex_v && ex_we && ex_rd == int'(id_rs1) && id_rs1 != 0;
      e2 = id_rs2_used && ex_v && ex_we && ex_rd == int'(id_rs2) && id_rs2 != 0;
      m1 = id_rs1_used && mem_v && mem_we && mem_rd == int'(id_rs1) && id_rs1 != 0;
      m2 = id_rs2_used && mem_v && mem_we && mem_rd == int'(id_rs2) && id_rs2 != 0;
      fe1 = e1 && !ex_ld;
      fe2 = e2 && !ex_ld;
      lu = id_valid && ex_ld && (e1 || e2);
      sid = busy || lu;
      iss = id_valid && !sid && !flush;
      exp = rst ? 8'b0 : {fe1, m1 && !fe1, fe2, m2 && !fe2, sid, busy, iss, !busy && !iss};
      @(negedge clk);
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL random%0d got=%b exp=%b", n, outs, exp); end
      if (rst) begin
        ex_v = 0; mem_v = 0; hold = 0;
      end else begin
        mem_v = !busy && ex_v; mem_we = ex_we; mem_rd = ex_rd;
        if (!busy) begin
          ex_v = iss; ex_we = id_we; ex_rd = int'(id_rd); ex_ld = id_is_load;
        end
        hold = (iss && id_is_div) ? DIV_LAT - 1 : busy ? hold - 1 : 0;
      end
      step();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_double_hit();
    test_load_use();
    test_divide();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
